flatten_lane_scheduler: RTL and testbench
=========================================

// Module: flatten_lane_scheduler
// PURPOSE
//   Sequences the per-image pixel streams of the last conv stage onto the NumOfInputs shared input
//   lanes of flattening_layer. Each pixel period is split into CyclesPerPixel slots; each slot serves
//   one group of NumOfInputs images and raises the matching in_valid bits. After the last pixel, the
//   block drives ImageSize all-invalid cycles, which flattening_layer needs to flush, then signals done.
// PARAMETERS
//   BitSize        4  pixel width in bits
//   ImageSize      4  pixels per image per frame; also number of flush cycles
//   NumOfImages    4  number of image (channel) sources
//   NumOfInputs    2  shared lanes into flattening_layer
//   CyclesPerPixel 2  slots per pixel period; must equal ceil(NumOfImages/NumOfInputs)
// PORTS
//   clk        in   1                        clock, all state on rising edge
//   res_n      in   1                        reset, asynchronous, ACTIVE-HIGH (1 = in reset)
//   start      in   1                        begin a frame; sampled only in IDLE
//   src_valid  in   NumOfImages              image i presents a pixel
//   src_data   in   NumOfImages x BitSize    pixel of image i
//   src_ready  out  NumOfImages              pixel of image i consumed this cycle (combinational)
//   fl_ready   in   1                        flattening_layer may accept a slot
//   fl_valid   out  NumOfImages              to flattening_layer in_valid, registered
//   fl_data    out  NumOfInputs x BitSize    to flattening_layer in_data, registered
//   busy       out  1                        high in any state except IDLE
//   done       out  1                        one-cycle pulse at end of flush
// BEHAVIOUR
//   Reset: state=IDLE, slot_cnt=pix_cnt=flush_cnt=0. fl_valid, fl_data, done and busy are 0.
//     src_ready is 0. Reset mid-frame abandons the frame and issues no done.
//   Groups: slot s, lane k carries image g = s*NumOfInputs+k.
//     When g >= NumOfImages, the lane's data is 0 and no valid bit is set.
//   FSM IDLE: on start=1 go to ISSUE. Next edge: slot_cnt=0, pix_cnt=0.
//   FSM ISSUE: the slot is accepted when fl_ready=1 and src_valid=1 for every existing image in group slot_cnt.
//     On accept:
//       - src_ready=1 for those images only, in the same cycle.
//       - Next edge: fl_valid has exactly those bits set; fl_data[k]=src_data[g].
//       - slot_cnt increments.
//     On slot wrap (CyclesPerPixel-1 -> 0), pix_cnt increments.
//     After the last slot of pixel ImageSize-1 is accepted, go to FLUSH with flush_cnt=0.
//     No accept: next edge fl_valid=0; fl_data holds its last value; counters hold. This is a stall
//       with no partial-group issue.
//   FSM FLUSH: fl_valid=0, fl_data=0. flush_cnt increments every cycle, independent of fl_ready.
//     At flush_cnt=ImageSize-1 go to DONE.
//   FSM DONE: done=1 for exactly one cycle, then IDLE. busy drops in IDLE.
//   start while busy is ignored. start in the same cycle that DONE exits is not sampled;
//     the earliest restart is the first IDLE cycle.
//   Latency: first fl_valid is 2 cycles after start if sources and fl_ready are high.
//     Unstalled frame = ImageSize*CyclesPerPixel issue cycles + ImageSize flush cycles + 1 done cycle.
//   src_ready is never asserted outside ISSUE. src_valid in other states has no effect.
// TESTING
//   1 Default params, all src_valid=1, fl_ready=1, image i pixel p = i+p, start pulse ->
//     fl_valid alternates 0011,1100 for 8 cycles; fl_data = {1,0},{3,2} for p=0, etc.
//     Then 4 cycles fl_valid=0, then done=1 for one cycle.
//   2 Same, fl_ready low for 3 cycles mid-pixel -> no fl_valid and no src_ready while low;
//     issue resumes at the same slot; frame length +3 cycles.
//   3 src_valid[2] low for 2 cycles at slot 1 -> stall.
//     src_ready[3] and src_ready[2] both stay 0; slot 1 issues only when both valid.
//   4 NumOfImages=3, NumOfInputs=2 -> slot 1 fl_valid=0100, fl_data lane 1 = 0, valid bit 3 never set.
//   5 res_n=1 asynchronously during pixel 2 -> outputs 0 immediately; no done.
//     A new start after release runs a full correct frame.
//   6 start pulsed during ISSUE and FLUSH -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/flatten_lane_scheduler.sv
// Time-multiplexes NumOfImages pixel sources onto NumOfInputs shared lanes into flattening_layer,
// one image group per slot, then drives ImageSize all-invalid flush cycles and pulses done.
module flatten_lane_sel #(
  parameter int BitSize     = 4,
  parameter int NumOfImages = 4,
  parameter int NumOfInputs = 2,
  parameter int Lane        = 0,
  parameter int SW          = 1
) (
  input  logic [SW-1:0]                  slot,
  input  logic [NumOfImages-1:0]         src_valid,
  input  logic [NumOfImages*BitSize-1:0] src_data,
  output logic [BitSize-1:0]             data,
  output logic                           ok,
  output logic [NumOfImages-1:0]         sel
);
  // A lane whose image index is out of range stays idle and never blocks the slot.
  always_comb begin
    data = '0;
    ok   = 1'b1;
    sel  = '0;
    for (int i = 0; i < NumOfImages; i++) begin
      if (i == int'(slot) * NumOfInputs + Lane) begin
        data   = src_data[i*BitSize +: BitSize];
        ok     = src_valid[i];
        sel[i] = 1'b1;
      end
    end
  end
endmodule

module flatten_lane_scheduler #(
  parameter int BitSize        = 4,
  parameter int ImageSize      = 4,
  parameter int NumOfImages    = 4,
  parameter int NumOfInputs    = 2,
  parameter int CyclesPerPixel = 2
) (
  input  logic                           clk,
  input  logic                           res_n,
  input  logic                           start,
  input  logic [NumOfImages-1:0]         src_valid,
  input  logic [NumOfImages*BitSize-1:0] src_data,
  output logic [NumOfImages-1:0]         src_ready,
  input  logic                           fl_ready,
  output logic [NumOfImages-1:0]         fl_valid,
  output logic [NumOfInputs*BitSize-1:0] fl_data,
  output logic                           busy,
  output logic                           done
);
  localparam int SW = (CyclesPerPixel > 1) ? $clog2(CyclesPerPixel) : 1;
  localparam int PW = (ImageSize > 1) ? $clog2(ImageSize) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} state_t;
  state_t state, state_nxt;

  logic [SW-1:0] slot_cnt, slot_nxt;
  logic [PW-1:0] pix_cnt, pix_nxt, flush_cnt, flush_nxt;

  logic [NumOfInputs-1:0]                  lane_ok;
  logic [NumOfInputs-1:0][NumOfImages-1:0] lane_sel;
  logic [NumOfInputs-1:0][BitSize-1:0]     lane_data;
  logic [NumOfImages-1:0]                  grp_mask;
  logic accept, last_slot, last_pix, last_flush;

  genvar k;
  generate
    for (k = 0; k < NumOfInputs; k++) begin : g_lane
      flatten_lane_sel #(
        .BitSize(BitSize), .NumOfImages(NumOfImages), .NumOfInputs(NumOfInputs),
        .Lane(k), .SW(SW)
      ) u_lane (
        .slot(slot_cnt), .src_valid(src_valid), .src_data(src_data),
        .data(lane_data[k]), .ok(lane_ok[k]), .sel(lane_sel[k])
      );
    end
  endgenerate

  always_comb begin
    grp_mask = '0;
    for (int j = 0; j < NumOfInputs; j++) grp_mask = grp_mask | lane_sel[j];
  end

  // Whole group or nothing: a slot issues only when every existing image in it is valid.
  assign accept     = (state == ISSUE) && fl_ready && (&lane_ok);
  assign src_ready  = accept ? grp_mask : '0;
  assign last_slot  = (slot_cnt == SW'(CyclesPerPixel - 1));
  assign last_pix   = (pix_cnt == PW'(ImageSize - 1));
  assign last_flush = (flush_cnt == PW'(ImageSize - 1));
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_comb begin
    state_nxt = state;
    slot_nxt  = slot_cnt;
    pix_nxt   = pix_cnt;
    flush_nxt = flush_cnt;
    case (state)
      IDLE: if (start) begin
        state_nxt = ISSUE;
        slot_nxt  = '0;
        pix_nxt   = '0;
      end
      ISSUE: if (accept) begin
        if (last_slot) begin
          slot_nxt = '0;
          if (last_pix) begin
            state_nxt = FLUSH;
            flush_nxt = '0;
          end else begin
            pix_nxt = pix_cnt + PW'(1);
          end
        end else begin
          slot_nxt = slot_cnt + SW'(1);
        end
      end
      FLUSH: begin
        if (last_flush) state_nxt = DONE;
        else             flush_nxt = flush_cnt + PW'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res_n) begin
    if (res_n) begin
      state     <= IDLE;
      slot_cnt  <= '0;
      pix_cnt   <= '0;
      flush_cnt <= '0;
      fl_valid  <= '0;
      fl_data   <= '0;
    end else begin
      state     <= state_nxt;
      slot_cnt  <= slot_nxt;
      pix_cnt   <= pix_nxt;
      flush_cnt <= flush_nxt;
      fl_valid  <= accept ? grp_mask : '0;
      if (accept)              fl_data <= lane_data;
      else if (state == FLUSH) fl_data <= '0;
    end
  end
endmodule

// File: tb/tb_flatten_lane_scheduler.sv
// Directed bench: full frames, fl_ready and src_valid stalls, a 3-image variant,
// asynchronous mid-frame reset and start pulses while busy.
module tb_flatten_lane_scheduler;
  logic        clk = 1'b0;
  logic        res_n, start, start1, fl_ready, src_clr;
  logic [3:0]  sv0, sr0, fv0;
  logic [15:0] sd0;
  logic [7:0]  fd0, fd1;
  logic [2:0]  sv1, sr1, fv1;
  logic [11:0] sd1;
  logic        busy0, done0, busy1, done1;
  logic [2:0]  pc0 [4];
  logic [2:0]  pc1 [3];
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  flatten_lane_scheduler u0 (
    .clk(clk), .res_n(res_n), .start(start), .src_valid(sv0), .src_data(sd0),
    .src_ready(sr0), .fl_ready(fl_ready), .fl_valid(fv0), .fl_data(fd0),
    .busy(busy0), .done(done0));

  flatten_lane_scheduler #(.NumOfImages(3)) u1 (
    .clk(clk), .res_n(res_n), .start(start1), .src_valid(sv1), .src_data(sd1),
    .src_ready(sr1), .fl_ready(1'b1), .fl_valid(fv1), .fl_data(fd1),
    .busy(busy1), .done(done1));

  // Pixel sources: image i emits i+p, advancing p on each consumed pixel.
  always @(posedge clk or posedge res_n) begin
    if (res_n || src_clr) begin
      for (int i = 0; i < 4; i++) pc0[i] <= '0;
      for (int i = 0; i < 3; i++) pc1[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) if (sr0[i]) pc0[i] <= pc0[i] + 3'd1;
      for (int i = 0; i < 3; i++) if (sr1[i]) pc1[i] <= pc1[i] + 3'd1;
    end
  end

  always_comb begin
    sd0 = '0;
    sd1 = '0;
    for (int i = 0; i < 4; i++) sd0[i*4 +: 4] = 4'(i + int'(pc0[i]));
    for (int i = 0; i < 3; i++) sd1[i*4 +: 4] = 4'(i + int'(pc1[i]));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  // One frame on u0. kind 0 stalls via fl_ready, kind 1 via src_valid[2].
  task automatic do_frame(input int stall_c, input int stall_len, input int kind, input bit pulse);
    logic [7:0] prev, exp;
    int s, p;
    prev = '0;
    src_clr = 1'b1; tick; src_clr = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    chk("busy_after_start", busy0, 1);
    chk("no_valid_yet", fv0, 0);
    for (int c = 0; c < 8; c++) begin
      s = c % 2;
      p = c / 2;
      if (c == stall_c) begin
        for (int n = 0; n < stall_len; n++) begin
          if (kind == 0) fl_ready = 1'b0;
          else           sv0[2] = 1'b0;
          #1;
          chk("stall_src_ready", sr0, 0);
          tick;
          chk("stall_fl_valid", fv0, 0);
          chk("stall_fl_data_hold", fd0, prev);
        end
        fl_ready = 1'b1;
        sv0 = 4'hf;
      end
      if (pulse && c == 3) start = 1'b1;
      #1;
      chk("src_ready", sr0, s ? 4'b1100 : 4'b0011);
      tick;
      start = 1'b0;
      chk("fl_valid", fv0, s ? 4'b1100 : 4'b0011);
      exp = s ? {4'(3 + p), 4'(2 + p)} : {4'(1 + p), 4'(p)};
      chk("fl_data", fd0, exp);
      chk("done_in_issue", done0, 0);
      prev = exp;
    end
    for (int f = 0; f < 4; f++) begin
      if (pulse && f == 1) start = 1'b1;
      tick;
      start = 1'b0;
      chk("flush_valid", fv0, 0);
      chk("flush_data", fd0, 0);
      chk("flush_src_ready", sr0, 0);
      chk("done_pulse", done0, (f == 3) ? 1 : 0);
      chk("busy_flush", busy0, 1);
    end
    if (pulse) start = 1'b1;
    tick;
    start = 1'b0;
    chk("done_one_cycle", done0, 0);
    chk("busy_idle", busy0, 0);
    if (pulse) begin
      repeat (3) tick;
      chk("no_restart", busy0, 0);
      chk("no_extra_done", done0, 0);
    end
  endtask

  initial begin
    logic seen_done;
    int s, p;
    res_n = 1'b1; start = 1'b0; start1 = 1'b0; fl_ready = 1'b1; src_clr = 1'b0;
    sv0 = 4'hf; sv1 = 3'h7;
    repeat (2) tick;
    chk("rst_fl_valid", fv0, 0);
    chk("rst_fl_data", fd0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_src_ready", sr0, 0);
    res_n = 1'b0;
    tick;
    chk("idle_src_ready", sr0, 0);

    do_frame(-1, 0, 0, 1'b0);
    do_frame(3, 3, 0, 1'b0);
    do_frame(1, 2, 1, 1'b0);

    // 3 images on 2 lanes: slot 1 lane 1 is empty
    src_clr = 1'b1; tick; src_clr = 1'b0;
    start1 = 1'b1; tick; start1 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      s = c % 2;
      p = c / 2;
      chk("n3_src_ready", sr1, s ? 3'b100 : 3'b011);
      tick;
      chk("n3_fl_valid", fv1, s ? 3'b100 : 3'b011);
      chk("n3_fl_data", fd1, s ? {4'h0, 4'(2 + p)} : {4'(1 + p), 4'(p)});
    end
    repeat (3) tick;
    chk("n3_no_done_early", done1, 0);
    tick;
    chk("n3_done", done1, 1);
    tick;
    chk("n3_idle", busy1, 0);

    // asynchronous reset during pixel 2
    src_clr = 1'b1; tick; src_clr = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    repeat (4) tick;
    chk("pre_rst_valid", fv0, 4'b1100);
    #2;
    res_n = 1'b1;
    #1;
    chk("arst_fl_valid", fv0, 0);
    chk("arst_fl_data", fd0, 0);
    chk("arst_busy", busy0, 0);
    chk("arst_src_ready", sr0, 0);
    repeat (2) tick;
    res_n = 1'b0;
    seen_done = 1'b0;
    repeat (20) begin
      tick;
      seen_done = seen_done | done0;
    end
    chk("arst_no_done", seen_done, 0);
    do_frame(-1, 0, 0, 1'b0);

    do_frame(-1, 0, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
